// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the issue stage, the ALU sequencer and
// the writeback stage.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer that raises valid keeps
// valid and its payload stable until that edge. A consumer may raise or lower
// ready at any time. ready never depends combinationally on valid.
interface alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [4:0]       req_shamt;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_err;

    // Issue/writeback side of the bundle.
    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
    );

    // Sequencer side of the bundle.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller around an external single-pass 32-bit ALU.
// Single-pass ops run once through the ALU. Shifts by N run as N single-bit
// ALU shifts. MUL runs as 32 shift-and-add steps with the adds done in the
// ALU. One operation is in flight at a time. The result is held until
// writeback accepts it.
module alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_MUL   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    state_t           state_q, state_d;
    // opa: operand A, shift work register, or MUL accumulator
    logic [WIDTH-1:0] opa_q, opa_d;
    // opb: operand B, or MUL multiplicand
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [3:0]       op_q, op_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step;

    // Next-state, datapath updates and combinational ALU drive
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        mplr_d  = mplr_q;
        op_d    = op_q;
        count_d = count_q;
        sign_d  = sign_q;
        data_d  = data_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = err_q;
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 3'b000;
        step    = alu_out;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    sign_d  = bus.req_a[WIDTH-1];
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    if (bus.req_op <= OP_XOR) begin
                        opa_d   = bus.req_a;
                        opb_d   = bus.req_b;
                        state_d = ST_EXEC;
                    end else if (bus.req_op <= OP_SRA) begin
                        opa_d   = bus.req_a;
                        count_d = CNTW'(bus.req_shamt);
                        state_d = ST_SHIFT;
                    end else if (bus.req_op == OP_MUL) begin
                        opa_d   = '0;
                        opb_d   = bus.req_a;
                        mplr_d  = bus.req_b;
                        count_d = CNTW'(WIDTH);
                        state_d = ST_MUL;
                    end else begin
                        data_d  = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_EXEC: begin
                alu_a   = opa_q;
                alu_b   = opb_q;
                alu_sel = op_q[2:0];
                data_d  = alu_out;
                zero_d  = alu_zero;
                carry_d = (op_q == OP_ADD) ? alu_carry : 1'b0;
                state_d = ST_DONE;
            end

            ST_SHIFT: begin
                if (count_q == '0) begin
                    // Zero-length shift: pass A through an ADD with 0.
                    alu_a   = opa_q;
                    alu_sel = 3'b000;
                    data_d  = opa_q;
                    zero_d  = alu_zero;
                    state_d = ST_DONE;
                end else begin
                    alu_a   = opa_q;
                    alu_sel = op_q[2:0];
                    // The ALU shifts right logically, so SRA restores the sign bit.
                    if (op_q == OP_SRA) begin
                        step[WIDTH-1] = sign_q;
                    end
                    opa_d   = step;
                    count_d = count_q - CNTW'(1);
                    if (count_q == CNTW'(1)) begin
                        data_d  = step;
                        zero_d  = (op_q == OP_SRA) ? (step == '0) : alu_zero;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_MUL: begin
                alu_a   = opa_q;
                alu_b   = mplr_q[0] ? opb_q : '0;
                alu_sel = 3'b000;
                opa_d   = alu_out;
                carry_d = carry_q | alu_carry;
                opb_d   = opb_q << 1;
                mplr_d  = mplr_q >> 1;
                count_d = count_q - CNTW'(1);
                if (count_q == CNTW'(1)) begin
                    data_d  = alu_out;
                    zero_d  = alu_zero;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            mplr_q  <= '0;
            op_q    <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            mplr_q  <= mplr_d;
            op_q    <= op_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_DONE);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_zero  = zero_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_err   = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU, an operation-level result
// model with a per-cycle compare process, and directed vectors whose
// expected values are written out by hand.
module tb_alu_sequencer;

    localparam int EW = 67;  // {due[31:0], err, carry, zero, data[31:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        alu_carry, alu_zero;
    logic [2:0]  state_dbg;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_zero  (alu_zero),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ALU model ----------------
    logic [32:0] sum33, dif33;
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        sum33     = {1'b0, alu_a} + {1'b0, alu_b};
        dif33     = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        case (alu_sel)
            3'b000: begin alu_out = sum33[31:0]; alu_carry = sum33[32]; end
            3'b001: begin alu_out = dif33[31:0]; alu_carry = dif33[32]; end
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            3'b101: begin alu_out = alu_a << 1; alu_carry = alu_a[31]; end
            3'b110: begin alu_out = alu_a >> 1; alu_carry = alu_a[0]; end
            default: begin alu_out = alu_a >> 1; alu_carry = alu_a[0]; end
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Operation-level result model.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] d, output logic z,
                                  output logic c, output logic e, output int k);
        logic [32:0] t;
        d = '0; c = 1'b0; e = 1'b0; k = 1;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; d = t[31:0]; c = t[32]; end
            4'd1: d = a - b;
            4'd2: d = a & b;
            4'd3: d = a | b;
            4'd4: d = a ^ b;
            4'd5: begin d = a << sh; k = (sh == 0) ? 1 : int'(sh); end
            4'd6: begin d = a >> sh; k = (sh == 0) ? 1 : int'(sh); end
            4'd7: begin d = $signed(a) >>> sh; k = (sh == 0) ? 1 : int'(sh); end
            4'd8: begin
                for (int i = 0; i < 32; i++) begin
                    if (b[i]) begin
                        t = {1'b0, d} + {1'b0, a << i};
                        d = t[31:0];
                        c = c | t[32];
                    end
                end
                k = 32;
            end
            default: begin e = 1'b1; k = 0; end
        endcase
        z = (d == 32'd0);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : cmp
        logic [EW-1:0] e;
        logic [31:0]   md;
        logic          mz, mc, me;
        int            mk;
        if (rst) begin
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                chk("req_ready_idle", bus.req_ready, 1);
                chk("rsp_valid_idle", bus.rsp_valid, 0);
                chk("alu_a_idle", alu_a, 0);
                chk("alu_b_idle", alu_b, 0);
                chk("alu_sel_idle", alu_sel, 0);
            end else begin
                e = exp_q[0];
                chk("req_ready_busy", bus.req_ready, 0);
                if (bus.rsp_valid) begin
                    if (!prev_valid) chk("rsp_latency", cyc, e[66:35]);
                    chk("rsp_data", bus.rsp_data, e[31:0]);
                    chk("rsp_zero", bus.rsp_zero, e[32]);
                    chk("rsp_carry", bus.rsp_carry, e[33]);
                    chk("rsp_err", bus.rsp_err, e[34]);
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end else if (cyc == int'(e[66:35])) begin
                    chk("rsp_valid_due", bus.rsp_valid, 1);
                end
            end
            prev_valid = bus.rsp_valid;
            if (bus.req_valid && bus.req_ready) begin
                model(bus.req_op, bus.req_a, bus.req_b, bus.req_shamt, md, mz, mc, me, mk);
                exp_q.push_back({32'(cyc + 1 + mk), me, mc, mz, md});
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] data;
        logic        z;
        logic        c;
        logic        e;
        int          k;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic pin(input vec_t v);
        logic [31:0] d;
        logic        z, c, e;
        int          k;
        model(v.op, v.a, v.b, v.sh, d, z, c, e, k);
        chk("model_data", d, v.data);
        chk("model_flags", {29'd0, e, c, z}, {29'd0, v.e, v.c, v.z});
        chk("model_k", k, v.k);
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_shamt = sh;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail("issue_accept");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail("wait_response");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0, 1};
        vecs[1]  = '{4'd1, 32'h00000007, 32'h00000005, 5'd0,  32'h00000002, 1'b0, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'd1, 32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'd3, 32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'd7, 32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 1'b0, 4};
        vecs[7]  = '{4'd6, 32'h80000000, 32'h00000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 1'b0, 4};
        vecs[8]  = '{4'd5, 32'h00000001, 32'h00000000, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'd5, 32'h00000003, 32'h00000000, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 31};
        vecs[10] = '{4'd6, 32'h80000000, 32'h00000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0, 31};
        vecs[11] = '{4'd7, 32'h7FFFFFFF, 32'h00000000, 5'd31, 32'h00000000, 1'b1, 1'b0, 1'b0, 31};
        vecs[12] = '{4'd7, 32'h80000000, 32'h00001234, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{4'd8, 32'h00000007, 32'h00000006, 5'd0,  32'h0000002A, 1'b0, 1'b0, 1'b0, 32};
        vecs[14] = '{4'd8, 32'h00000003, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 32};
        vecs[15] = '{4'hA, 32'h00000001, 32'h00000002, 5'd3,  32'h00000000, 1'b1, 1'b0, 1'b1, 0};
        vecs[16] = '{4'd0, 32'h00000001, 32'h00000002, 5'd0,  32'h00000003, 1'b0, 1'b0, 1'b0, 1};
        vecs[17] = '{4'd8, 32'h00000000, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 32};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_shamt = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_zero", bus.rsp_zero, 0);
        chk("reset_rsp_carry", bus.rsp_carry, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);

        // directed vectors, each pinned against its hand value first
        for (int i = 0; i < NV; i++) begin
            pin(vecs[i]);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            wait_idle();
        end

        // backpressure: hold the result 3 cycles while a new request waits
        begin
            vec_t bp_add, bp_xor;
            bit   seen = 1'b0;
            bp_add = '{4'd0, 32'h0000000A, 32'h00000014, 5'd0, 32'h0000001E, 1'b0, 1'b0, 1'b0, 1};
            bp_xor = '{4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1};
            pin(bp_add);
            pin(bp_xor);
            bus.rsp_ready = 1'b0;
            issue(bp_add.op, bp_add.a, bp_add.b, bp_add.sh);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin seen = 1'b1; break; end
            end
            if (!seen) timeout_fail("bp_rsp_valid");
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.req_op    = bp_xor.op;
            bus.req_a     = bp_xor.a;
            bus.req_b     = bp_xor.b;
            bus.req_shamt = bp_xor.sh;
            @(negedge clk);
            @(negedge clk);
            chk("bp_held_data", bus.rsp_data, 32'h0000001E);
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_next_accept", bus.req_ready, 1);
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            wait_idle();
        end

        // reset during cycle 10 of a MUL: no response may follow
        issue(4'd8, 32'h00000007, 32'h00000006, 5'd0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_sel", alu_sel, 0);
        chk("mid_rst_rsp_data", bus.rsp_data, 0);
        chk("mid_rst_rsp_carry", bus.rsp_carry, 0);
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
